// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: combinational instruction-memory port plus the decode handshake.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output imem_addr,
        input  imem_instr,
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Generic DEPTH-entry synchronous FIFO of {pc, instr}; flush empties it without clearing storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wr_data,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Flush wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per cycle into a skid FIFO.
// Optional MISALIGN_TRAP_EN: misaligned redirects raise misalign_fault and keep the PC.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_unit_if.master               bus,
    input  logic                       fetch_stall,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_target,
    output logic [$clog2(BUF_DEPTH):0] buf_count
`ifdef MISALIGN_TRAP_EN
    ,
    output logic                       misalign_fault
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redirect_pc;
    logic            push;
    logic            pop;
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = (buf_count != '0);
    assign bus.out_pc    = head.pc;
    assign bus.out_instr = head.instr;

    // A full buffer may still accept a fetch when decode drains the head the same cycle.
    assign pop  = bus.out_valid && bus.out_ready;
    assign push = !redirect_valid && !fetch_stall &&
                  ((buf_count < CNT_W'(BUF_DEPTH)) || pop);

    assign wr_entry.pc    = pc_q;
    assign wr_entry.instr = bus.imem_instr;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = (redirect_target[1:0] != 2'b00);
    assign redirect_pc = misaligned ? pc_q : (redirect_target & ~XLEN'(3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= redirect_valid && misaligned;
        end
    end
`else
    assign redirect_pc = redirect_target & ~XLEN'(3);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else if (push) begin
            pc_q <= pc_q + XLEN'(INSTR_BYTES);
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .count   (buf_count),
        .head    (head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus, expected accepts queued, monitor compares.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [1:0]  buf_count;
    logic [1:0]  buf_count2;
    int          checks;
    int          errors;

    fetch_entry_t exp_q  [$];
    fetch_entry_t exp2_q [$];

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    function automatic logic [31:0] imem_model(input logic [31:0] addr);
        return addr ^ 32'hC0DE_5A00;
    endfunction

    assign bus.imem_instr  = imem_model(bus.imem_addr);
    assign bus2.imem_instr = imem_model(bus2.imem_addr);

`ifdef MISALIGN_TRAP_EN
    logic misalign_fault;
    logic misalign_fault2;
`endif

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .fetch_stall     (fetch_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .buf_count       (buf_count)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_fault  (misalign_fault)
`endif
    );

    fetch_unit #(
        .RESET_PC  (32'hFFFF_FFF8),
        .BUF_DEPTH (2)
    ) dut_wrap (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus2),
        .fetch_stall     (1'b0),
        .redirect_valid  (1'b0),
        .redirect_target (32'h0),
        .buf_count       (buf_count2)
`ifdef MISALIGN_TRAP_EN
        ,
        .misalign_fault  (misalign_fault2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic stall,
                                 input logic redir, input logic [31:0] target);
        @(posedge clk);
        #1;
        bus.out_ready   = ready;
        fetch_stall     = stall;
        redirect_valid  = redir;
        redirect_target = target;
    endtask

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = imem_model(pc);
        return e;
    endfunction

    // Main DUT: every accepted head must match the next queued entry; a redirect cycle never accepts.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && bus.out_valid && bus.out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_accept: got pc %h expected none", bus.out_pc);
            end else begin
                e = exp_q.pop_front();
                checkOutput("accept_pc", bus.out_pc, e.pc);
                checkOutput("accept_instr", bus.out_instr, e.instr);
            end
        end
    end

    // Wrap DUT: only its first few accepts after the initial reset are scored.
    always @(negedge clk) begin
        fetch_entry_t e;
        if (!rst && bus2.out_valid && bus2.out_ready && exp2_q.size() != 0) begin
            e = exp2_q.pop_front();
            checkOutput("wrap_pc", bus2.out_pc, e.pc);
            checkOutput("wrap_instr", bus2.out_instr, e.instr);
        end
    end

    initial begin
        logic [31:0] resume_pc;
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.out_ready   = 1'b1;
        bus2.out_ready  = 1'b1;
        fetch_stall     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("reset_buf_count", {30'b0, buf_count}, 32'h0);
        checkOutput("reset_out_pc", bus.out_pc, 32'h0);
        checkOutput("reset_out_instr", bus.out_instr, 32'h0);
        checkOutput("reset_imem_addr", bus.imem_addr, 32'h0);
        checkOutput("reset_wrap_addr", bus2.imem_addr, 32'hFFFF_FFF8);

        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h8));
        exp_q.push_back(mk(32'hC));
        exp_q.push_back(mk(32'h10));
        exp_q.push_back(mk(32'h14));
        exp2_q.push_back(mk(32'hFFFF_FFF8));
        exp2_q.push_back(mk(32'hFFFF_FFFC));
        exp2_q.push_back(mk(32'h0000_0000));

        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Back-pressure: buffer fills, PC stops, head holds.
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("bp_buf_count", {30'b0, buf_count}, 32'h2);
        checkOutput("bp_out_valid", {31'b0, bus.out_valid}, 32'h1);
        checkOutput("bp_head_pc", bus.out_pc, 32'hC);
        checkOutput("bp_pc_held", bus.imem_addr, 32'h14);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with full buffer and decode ready: stale head 0x18 must never be accepted.
        exp_q.push_back(mk(32'h100));
        exp_q.push_back(mk(32'h104));
        exp_q.push_back(mk(32'h108));
        exp_q.push_back(mk(32'h10C));
        exp_q.push_back(mk(32'h110));
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_out_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("redir_buf_count", {30'b0, buf_count}, 32'h0);
        checkOutput("redir_imem_addr", bus.imem_addr, 32'h100);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_first_valid", {31'b0, bus.out_valid}, 32'h1);
        checkOutput("redir_first_pc", bus.out_pc, 32'h100);

        // Stall with two entries buffered: they drain, PC holds.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_pre_count", {30'b0, buf_count}, 32'h2);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stall_drained_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("stall_drained_count", {30'b0, buf_count}, 32'h0);
        checkOutput("stall_pc_held", bus.imem_addr, 32'h10C);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Misaligned redirect to 0x102 while pc_q = 0x118.
`ifdef MISALIGN_TRAP_EN
        resume_pc = 32'h118;
`else
        resume_pc = 32'h100;
`endif
        exp_q.push_back(mk(resume_pc));
        exp_q.push_back(mk(resume_pc + 32'h4));
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h102);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mis_out_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("mis_buf_count", {30'b0, buf_count}, 32'h0);
        checkOutput("mis_imem_addr", bus.imem_addr, resume_pc);
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis_fault_high", {31'b0, misalign_fault}, 32'h1);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        checkOutput("mis_fault_low", {31'b0, misalign_fault}, 32'h0);
`endif
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Asynchronous reset mid-stream with a full buffer.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("pre_rst_count", {30'b0, buf_count}, 32'h2);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
        checkOutput("async_rst_count", {30'b0, buf_count}, 32'h0);
        checkOutput("async_rst_pc", bus.imem_addr, 32'h0);
        exp_q.push_back(mk(32'h0));
        exp_q.push_back(mk(32'h4));
        exp_q.push_back(mk(32'h8));
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);

        checkOutput("exp_queue_drained", exp_q.size(), 32'h0);
        checkOutput("wrap_queue_drained", exp2_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
